// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg: N-channel, WIDTH-bit multiplexer with per-channel valid/ready
// handshakes and a one-deep registered output stage.
//   MODE 0: sel picks the channel (no grant if sel >= N or the channel is idle).
//   MODE 1: round-robin arbitration starting at rr_ptr; sel is ignored.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_data  [N*WIDTH]    channel i at bits [i*WIDTH +: WIDTH]
//   in_valid [N]          channel i offers data
//   in_ready [N]          channel i accepted this cycle (one-hot or zero)
//   sel      [SELW]       channel select (MODE 0 only)
//   out_data [WIDTH]      registered selected data
//   out_src  [SELW]       channel index that produced out_data
//   out_valid/out_ready   output handshake
module mux_nx1_reg #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int MODE  = 0,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_src_q,   out_src_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic [WIDTH-1:0] grant_data;
  logic             can_accept;
  logic             accept;
  int unsigned      idx;

  // Grant selection. Loops compare against constant indices so that an
  // out-of-range sel (N not a power of two) simply matches nothing.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant     = SELW'(i);
          grant_vld = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = 32'(rr_ptr_q) + k;
        if (idx >= N) idx = idx - N;
        for (int unsigned i = 0; i < N; i++) begin
          if (!grant_vld && idx == i && in_valid[i]) begin
            grant     = SELW'(i);
            grant_vld = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // out_ready feeds in_ready combinationally; rst_n gates acceptance so
  // in_ready stays low while reset is held.
  assign can_accept = !out_valid_q || out_ready;
  assign accept     = grant_vld && can_accept && rst_n;

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = accept && (grant == SELW'(i));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      out_data_d  = grant_data;
      out_src_d   = grant;
      out_valid_d = 1'b1;
      if (MODE == 1) begin
        rr_ptr_d = (grant == SELW'(N-1)) ? '0 : grant + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nx1_reg.sv
// tb_mux_nx1_reg: directed bench for mux_nx1_reg.
//   u_a: MODE 0, N=4, WIDTH=32    u_b: MODE 1, N=4, WIDTH=32
//   u_c: MODE 0, N=3, WIDTH=8 (non-power-of-two select range)
module tb_mux_nx1_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [127:0] a_data;  logic [3:0] a_valid, a_ready;  logic [1:0] a_sel;
  logic [31:0]  a_odata; logic [1:0] a_osrc; logic a_ovalid, a_oready;

  logic [127:0] b_data;  logic [3:0] b_valid, b_ready;  logic [1:0] b_sel;
  logic [31:0]  b_odata; logic [1:0] b_osrc; logic b_ovalid, b_oready;

  logic [23:0]  c_data;  logic [2:0] c_valid, c_ready;  logic [1:0] c_sel;
  logic [7:0]   c_odata; logic [1:0] c_osrc; logic c_ovalid, c_oready;

  mux_nx1_reg #(.WIDTH(32), .N(4), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .sel(a_sel), .out_data(a_odata), .out_src(a_osrc),
    .out_valid(a_ovalid), .out_ready(a_oready)
  );

  mux_nx1_reg #(.WIDTH(32), .N(4), .MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .sel(b_sel), .out_data(b_odata), .out_src(b_osrc),
    .out_valid(b_ovalid), .out_ready(b_oready)
  );

  mux_nx1_reg #(.WIDTH(8), .N(3), .MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid),
    .in_ready(c_ready), .sel(c_sel), .out_data(c_odata), .out_src(c_osrc),
    .out_valid(c_ovalid), .out_ready(c_oready)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Continuous properties sampled on the falling edge.
  bit          mon_on = 1'b0;
  int          rst_edges = 0;
  int          rst_p = 0;
  bit          a_stall_p = 1'b0, b_stall_p = 1'b0, c_stall_p = 1'b0;
  logic [33:0] a_hold_p, b_hold_p;
  logic [9:0]  c_hold_p;

  always @(negedge rst_n) rst_edges++;

  always @(negedge clk) begin
    if (mon_on) begin
      chk("a_onehot0", 64'($onehot0(a_ready)), 64'(1));
      chk("b_onehot0", 64'($onehot0(b_ready)), 64'(1));
      chk("c_onehot0", 64'($onehot0(c_ready)), 64'(1));
      chk("a_nox", 64'($isunknown({a_odata, a_osrc, a_ovalid, a_ready})), 64'(0));
      chk("b_nox", 64'($isunknown({b_odata, b_osrc, b_ovalid, b_ready})), 64'(0));
      chk("c_nox", 64'($isunknown({c_odata, c_osrc, c_ovalid, c_ready})), 64'(0));
      if (rst_n && rst_edges == rst_p) begin
        if (a_stall_p) chk("a_hold", 64'({a_osrc, a_odata}), 64'(a_hold_p));
        if (b_stall_p) chk("b_hold", 64'({b_osrc, b_odata}), 64'(b_hold_p));
        if (c_stall_p) chk("c_hold", 64'({c_osrc, c_odata}), 64'(c_hold_p));
      end
    end
    a_stall_p = rst_n && a_ovalid && !a_oready;
    b_stall_p = rst_n && b_ovalid && !b_oready;
    c_stall_p = rst_n && c_ovalid && !c_oready;
    a_hold_p  = {a_osrc, a_odata};
    b_hold_p  = {b_osrc, b_odata};
    c_hold_p  = {c_osrc, c_odata};
    rst_p     = rst_edges;
  end

  initial begin
    rst_n    = 1'b0;
    a_data   = {32'h44, 32'h33, 32'h22, 32'h11};
    a_valid  = 4'hF; a_sel = 2'd2; a_oready = 1'b1;
    b_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    b_valid  = 4'h0; b_sel = 2'd0; b_oready = 1'b1;
    c_data   = {8'h03, 8'h02, 8'h01};
    c_valid  = 3'b000; c_sel = 2'd0; c_oready = 1'b1;

    // Reset held with all channels valid
    #3;
    chk("rst_a_ovalid", 64'(a_ovalid), 64'(0));
    chk("rst_a_odata", 64'(a_odata), 64'(0));
    chk("rst_a_ready", 64'(a_ready), 64'(0));
    #20;
    chk("rst_a_ready2", 64'(a_ready), 64'(0));
    chk("rst_b_ovalid", 64'(b_ovalid), 64'(0));
    rst_n  = 1'b1;
    mon_on = 1'b1;
    #1;
    chk("sel2_ready", 64'(a_ready), 64'(4'b0100));
    step();
    chk("sel2_ovalid", 64'(a_ovalid), 64'(1));
    chk("sel2_odata", 64'(a_odata), 64'(32'h33));
    chk("sel2_osrc", 64'(a_osrc), 64'(2));

    // Back-to-back select
    a_sel = 2'd0; #1;
    chk("sel0_ready", 64'(a_ready), 64'(4'b0001));
    step();
    chk("sel0_ovalid", 64'(a_ovalid), 64'(1));
    chk("sel0_odata", 64'(a_odata), 64'(32'h11));
    chk("sel0_osrc", 64'(a_osrc), 64'(0));

    // Stall with changing sel/data
    a_sel = 2'd2;
    step();
    chk("st_load", 64'(a_odata), 64'(32'h33));
    a_oready = 1'b0; a_sel = 2'd1; a_data[32 +: 32] = 32'h55; #1;
    chk("st1_ready", 64'(a_ready), 64'(0));
    step();
    chk("st1_odata", 64'(a_odata), 64'(32'h33));
    chk("st1_osrc", 64'(a_osrc), 64'(2));
    a_sel = 2'd3; a_data[96 +: 32] = 32'h66; #1;
    chk("st2_ready", 64'(a_ready), 64'(0));
    step();
    chk("st2_odata", 64'(a_odata), 64'(32'h33));
    chk("st2_ovalid", 64'(a_ovalid), 64'(1));
    a_sel = 2'd0; #1;
    chk("st3_ready", 64'(a_ready), 64'(0));
    step();
    chk("st3_odata", 64'(a_odata), 64'(32'h33));
    a_oready = 1'b1; a_sel = 2'd1; #1;
    chk("swap_ready", 64'(a_ready), 64'(4'b0010));
    step();
    chk("swap_odata", 64'(a_odata), 64'(32'h55));
    chk("swap_osrc", 64'(a_osrc), 64'(1));
    chk("swap_ovalid", 64'(a_ovalid), 64'(1));
    a_valid = 4'h0; #1;
    chk("drain_ready", 64'(a_ready), 64'(0));
    step();
    chk("drain_ovalid", 64'(a_ovalid), 64'(0));
    chk("drain_odata", 64'(a_odata), 64'(32'h55));
    chk("drain_osrc", 64'(a_osrc), 64'(1));

    // Round-robin fairness
    b_valid = 4'hF; #1;
    chk("rr_first_ready", 64'(b_ready), 64'(4'b0001));
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_all_src", 64'(b_osrc), 64'(k % 4));
      chk("rr_all_data", 64'(b_odata), 64'(32'hA0 + (k % 4)));
    end
    b_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_13_src", 64'(b_osrc), 64'((k % 2) ? 3 : 1));
    end

    // Wrap and skip: grant 2 leaves rr_ptr=3, lone ch0 wraps to rr_ptr=1
    b_valid = 4'b0100;
    step();
    chk("rr_g2_src", 64'(b_osrc), 64'(2));
    b_valid = 4'b0001; #1;
    chk("rr_wrap_ready", 64'(b_ready), 64'(4'b0001));
    step();
    chk("rr_wrap_src", 64'(b_osrc), 64'(0));
    chk("rr_wrap_data", 64'(b_odata), 64'(32'hA0));
    b_valid = 4'h0;
    step();
    chk("rr_idle_ovalid", 64'(b_ovalid), 64'(0));
    step();
    chk("rr_idle_ovalid2", 64'(b_ovalid), 64'(0));
    chk("rr_idle_src", 64'(b_osrc), 64'(0));
    b_valid = 4'hF; #1;
    chk("rr_ptr1_ready", 64'(b_ready), 64'(4'b0010));
    step();
    chk("rr_ptr1_src", 64'(b_osrc), 64'(1));

    // Async reset while stalled
    b_oready = 1'b0; #1;
    chk("b_stall_ready", 64'(b_ready), 64'(0));
    step();
    chk("b_stall_src", 64'(b_osrc), 64'(1));
    chk("b_stall_ovalid", 64'(b_ovalid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ovalid", 64'(b_ovalid), 64'(0));
    chk("arst_odata", 64'(b_odata), 64'(0));
    chk("arst_osrc", 64'(b_osrc), 64'(0));
    chk("arst_ready", 64'(b_ready), 64'(0));
    #3 rst_n = 1'b1;
    b_oready = 1'b1; #1;
    chk("post_rst_ready", 64'(b_ready), 64'(4'b0001));
    step();
    chk("post_rst_src", 64'(b_osrc), 64'(0));
    chk("post_rst_data", 64'(b_odata), 64'(32'hA0));

    // Illegal select on N=3
    c_valid = 3'b111; c_sel = 2'd3; #1;
    chk("c_sel3_ready", 64'(c_ready), 64'(0));
    step();
    chk("c_sel3_ovalid", 64'(c_ovalid), 64'(0));
    c_sel = 2'd2; #1;
    chk("c_sel2_ready", 64'(c_ready), 64'(3'b100));
    step();
    chk("c_sel2_ovalid", 64'(c_ovalid), 64'(1));
    chk("c_sel2_odata", 64'(c_odata), 64'(8'h03));
    chk("c_sel2_osrc", 64'(c_osrc), 64'(2));
    c_sel = 2'd3;
    step();
    chk("c_sel3_drain", 64'(c_ovalid), 64'(0));
    chk("c_sel3_keep", 64'(c_odata), 64'(8'h03));

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
